// File: rtl/rx_unpacker.sv
// Drains 32-bit RX FIFO words to the FX2 as 16-bit half-words, low half first,
// capping each read burst at 256 half-words and flagging when a full packet is buffered.
module rx_unpacker #(
   parameter int unsigned USEDW_WIDTH = 12,
   parameter int unsigned PKT_THRESH  = 128
) (
   input  logic                   usbclk,
   input  logic                   bus_reset,
   input  logic                   RD_fx2,
   input  logic [31:0]            fifo_q,
   input  logic                   fifo_empty,
   input  logic [USEDW_WIDTH-1:0] fifo_usedw,
   output logic                   fifo_rdreq,
   output logic [15:0]            usbdata,
   output logic                   pkt_ready,
   output logic                   underrun
);

   localparam int unsigned CNT_WIDTH = 9;
   localparam logic [USEDW_WIDTH-1:0] PKT_THRESH_W = USEDW_WIDTH'(PKT_THRESH);

   logic [CNT_WIDTH-1:0] read_count_q, read_count_d;
   logic                 half_q, half_d;
   logic [15:0]          usbdata_q, usbdata_d;
   logic                 pkt_ready_q, pkt_ready_d;
   logic                 underrun_q, underrun_d;
   logic                 rd_ok;

   // Burst counter, read acceptance and half-word selection.
   always_comb begin
      read_count_d = read_count_q;
      half_d       = half_q;
      usbdata_d    = usbdata_q;
      underrun_d   = underrun_q;
      fifo_rdreq   = 1'b0;
      pkt_ready_d  = (fifo_usedw >= PKT_THRESH_W);

      // Bit 8 set means 256 reads taken; further strobes are ignored until RD_fx2 drops.
      rd_ok = RD_fx2 & ~read_count_q[8] & ~bus_reset;

      if (RD_fx2 && !read_count_q[8]) begin
         read_count_d = read_count_q + CNT_WIDTH'(1);
      end else if (!RD_fx2) begin
         read_count_d = '0;
      end

      if (rd_ok) begin
         if (fifo_empty) begin
            usbdata_d  = 16'h0000;
            underrun_d = 1'b1;
         end else if (!half_q) begin
            usbdata_d = fifo_q[15:0];
            half_d    = 1'b1;
         end else begin
            usbdata_d  = fifo_q[31:16];
            half_d     = 1'b0;
            fifo_rdreq = 1'b1;
         end
      end
   end

   always_ff @(posedge usbclk) begin
      if (bus_reset) begin
         read_count_q <= '0;
         half_q       <= 1'b0;
         usbdata_q    <= 16'h0000;
         pkt_ready_q  <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         read_count_q <= read_count_d;
         half_q       <= half_d;
         usbdata_q    <= usbdata_d;
         pkt_ready_q  <= pkt_ready_d;
         underrun_q   <= underrun_d;
      end
   end

   assign usbdata   = usbdata_q;
   assign pkt_ready = pkt_ready_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_rx_unpacker.sv
// Self-checking bench for rx_unpacker: show-ahead FIFO model, vector table,
// and hand-written burst-cap and gapped-read sequences.
module tb_rx_unpacker;

   localparam int unsigned USEDW_WIDTH = 12;

   logic                   usbclk;
   logic                   bus_reset;
   logic                   RD_fx2;
   logic [31:0]            fifo_q;
   logic                   fifo_empty;
   logic [USEDW_WIDTH-1:0] fifo_usedw;
   logic                   fifo_rdreq;
   logic [15:0]            usbdata;
   logic                   pkt_ready;
   logic                   underrun;

   rx_unpacker #(.USEDW_WIDTH(USEDW_WIDTH), .PKT_THRESH(128)) dut (
      .usbclk     (usbclk),
      .bus_reset  (bus_reset),
      .RD_fx2     (RD_fx2),
      .fifo_q     (fifo_q),
      .fifo_empty (fifo_empty),
      .fifo_usedw (fifo_usedw),
      .fifo_rdreq (fifo_rdreq),
      .usbdata    (usbdata),
      .pkt_ready  (pkt_ready),
      .underrun   (underrun)
   );

   initial usbclk = 1'b0;
   always #5 usbclk = ~usbclk;

   typedef struct {
      logic        rst;
      logic        rd;
      logic [11:0] usedw;
      logic        push;
      logic [31:0] pword;
      logic        e_rdreq;
      logic [15:0] e_data;
      logic        e_und;
      logic        e_pkt;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] data;
      logic        und;
      logic        pkt;
      logic        chk_pkt;
   } exp_t;

   logic [31:0] fq[$];
   exp_t        sb[$];
   int          passed = 0;
   int          total  = 0;
   int          pops   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic refresh();
      fifo_empty = (fq.size() == 0);
      fifo_q     = fifo_empty ? 32'hDEAD_BEEF : fq[0];
   endtask

   task automatic push_word(input logic [31:0] w);
      fq.push_back(w);
      refresh();
   endtask

   // Inputs already driven at the negedge; check the pop strobe, clock, then check outputs.
   task automatic tick(input string name, input logic e_rdreq, input logic [15:0] e_data,
                       input logic e_und, input logic e_pkt, input logic chk_pkt);
      exp_t e;
      exp_t got;
      logic rdreq_s;
      e.name = name; e.data = e_data; e.und = e_und; e.pkt = e_pkt; e.chk_pkt = chk_pkt;
      sb.push_back(e);
      #1;
      rdreq_s = fifo_rdreq;
      chk({name, ".rdreq"}, 32'(rdreq_s), 32'(e_rdreq));
      @(posedge usbclk);
      #1;
      if (rdreq_s) begin
         if (fq.size() > 0) void'(fq.pop_front());
         pops++;
         refresh();
      end
      if (sb.size() == 0) begin
         chk({name, ".scoreboard"}, 32'(0), 32'(1));
      end else begin
         got = sb.pop_front();
         chk({got.name, ".usbdata"}, 32'(usbdata), 32'(got.data));
         chk({got.name, ".underrun"}, 32'(underrun), 32'(got.und));
         if (got.chk_pkt) chk({got.name, ".pkt_ready"}, 32'(pkt_ready), 32'(got.pkt));
      end
      @(negedge usbclk);
   endtask

   function automatic logic [15:0] hw(input int base, input int k);
      return 16'(base + k);
   endfunction

   vec_t vecs[20];

   initial begin
      int k;
      int pops0;
      bus_reset  = 1'b1;
      RD_fx2     = 1'b0;
      fifo_usedw = '0;
      refresh();

      //           rst   rd    usedw   push  pword          rdreq data      und   pkt
      vecs[0]  = '{1'b1, 1'b0, 12'd0,   1'b1, 32'h2222_1111, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 12'd0,   1'b1, 32'h4444_3333, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 12'd0,   1'b0, 32'h0,         1'b0, 16'h1111, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 12'd0,   1'b0, 32'h0,         1'b1, 16'h2222, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 12'd0,   1'b0, 32'h0,         1'b0, 16'h3333, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 12'd0,   1'b0, 32'h0,         1'b1, 16'h4444, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 12'd127, 1'b0, 32'h0,         1'b0, 16'h4444, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 12'd128, 1'b0, 32'h0,         1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 12'd127, 1'b0, 32'h0,         1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 12'd4095,1'b1, 32'hBBBB_AAAA, 1'b0, 16'hAAAA, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 12'd0,   1'b0, 32'h0,         1'b1, 16'hBBBB, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 12'd200, 1'b1, 32'hBBBB_AAAA, 1'b0, 16'hBBBB, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 12'd200, 1'b1, 32'hDDDD_CCCC, 1'b0, 16'hBBBB, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 12'd200, 1'b0, 32'h0,         1'b0, 16'hAAAA, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 12'd200, 1'b0, 32'h0,         1'b1, 16'hBBBB, 1'b1, 1'b1};
      vecs[15] = '{1'b0, 1'b1, 12'd200, 1'b0, 32'h0,         1'b0, 16'hCCCC, 1'b1, 1'b1};
      vecs[16] = '{1'b1, 1'b1, 12'd200, 1'b0, 32'h0,         1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 12'd200, 1'b0, 32'h0,         1'b0, 16'hCCCC, 1'b0, 1'b1};
      vecs[18] = '{1'b0, 1'b1, 12'd200, 1'b0, 32'h0,         1'b1, 16'hDDDD, 1'b0, 1'b1};
      vecs[19] = '{1'b0, 1'b0, 12'd200, 1'b0, 32'h0,         1'b0, 16'hDDDD, 1'b0, 1'b1};

      @(negedge usbclk);
      for (int i = 0; i < 20; i++) begin
         if (vecs[i].push) push_word(vecs[i].pword);
         bus_reset  = vecs[i].rst;
         RD_fx2     = vecs[i].rd;
         fifo_usedw = vecs[i].usedw;
         tick($sformatf("vec%0d", i), vecs[i].e_rdreq, vecs[i].e_data,
              vecs[i].e_und, vecs[i].e_pkt, 1'b1);
      end
      chk("vec.fifo_drained", 32'(fq.size()), 32'(0));

      // Gapped reads, one strobe every other cycle, over 4 words.
      fifo_usedw = '0;
      for (int i = 0; i < 4; i++) push_word({hw(16'h5000, 2*i+1), hw(16'h5000, 2*i)});
      k = 0;
      for (int c = 0; c < 16; c++) begin
         RD_fx2 = (c % 2 == 0);
         if (RD_fx2) begin
            tick($sformatf("gap%0d", c), k[0], hw(16'h5000, k), 1'b0, 1'b0, 1'b0);
            k++;
         end else begin
            tick($sformatf("gap%0d", c), 1'b0, hw(16'h5000, k-1), 1'b0, 1'b0, 1'b0);
         end
      end
      chk("gap.fifo_drained", 32'(fq.size()), 32'(0));

      // 300-cycle burst: only 256 half-words / 128 pops are taken.
      for (int i = 0; i < 140; i++) push_word({hw(16'h1000, 2*i+1), hw(16'h1000, 2*i)});
      pops0 = pops;
      k = 0;
      RD_fx2 = 1'b1;
      for (int c = 0; c < 300; c++) begin
         if (k < 256) begin
            tick($sformatf("burst%0d", c), k[0], hw(16'h1000, k), 1'b0, 1'b0, 1'b0);
            k++;
         end else begin
            tick($sformatf("burst%0d", c), 1'b0, hw(16'h1000, 255), 1'b0, 1'b0, 1'b0);
         end
      end
      chk("burst.pops", 32'(pops - pops0), 32'(128));
      RD_fx2 = 1'b0;
      tick("burst.gap", 1'b0, hw(16'h1000, 255), 1'b0, 1'b0, 1'b0);
      RD_fx2 = 1'b1;
      tick("burst2.lo", 1'b0, hw(16'h1000, 256), 1'b0, 1'b0, 1'b0);
      tick("burst2.hi", 1'b1, hw(16'h1000, 257), 1'b0, 1'b0, 1'b0);
      RD_fx2 = 1'b0;
      tick("burst2.idle", 1'b0, hw(16'h1000, 257), 1'b0, 1'b0, 1'b0);
      chk("burst.fifo_left", 32'(fq.size()), 32'(11));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
